// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the i-cache and d-cache, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is data priority plus a starvation limit.
module sram_like_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mst_req,
  output logic        mst_wr,
  output logic [1:0]  mst_size,
  output logic [31:0] mst_addr,
  output logic [31:0] mst_wdata,
  input  logic [31:0] mst_rdata,
  input  logic        mst_addr_ok,
  input  logic        mst_data_ok
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic {GNT_DATA = 1'b0, GNT_INST = 1'b1} grant_t;

  state_t state, state_nxt;
  grant_t grant, grant_nxt;
  logic   inst_wins;
  logic   gnt_req;
  logic   arb_start;

  assign arb_start = (state == S_IDLE) && (inst_req || data_req);

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant;

  always_comb begin
    inst_wins = inst_req && (!data_req || (last_grant == GNT_DATA));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_DATA;
    end else if (arb_start) begin
      last_grant <= grant_nxt;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_comb begin
    inst_wins = inst_req && (!data_req || (starve_cnt == LIMIT));
  end

  // Counts data grants that overtook a waiting inst request; saturates so inst is forced next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (arb_start) begin
      if (inst_wins) begin
        starve_cnt <= 4'd0;
      end else if (inst_req && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= GNT_DATA;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  assign gnt_req = (grant == GNT_INST) ? inst_req : data_req;

  // Bridge accepting the address wins over a same-cycle request drop, since the port also sees addr_ok.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    mst_req      = 1'b0;
    mst_wr       = 1'b0;
    mst_size     = 2'd0;
    mst_addr     = 32'd0;
    mst_wdata    = 32'd0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (inst_req || data_req) begin
          state_nxt = S_ADDR;
          grant_nxt = inst_wins ? GNT_INST : GNT_DATA;
        end
      end
      S_ADDR: begin
        mst_req = gnt_req;
        if (grant == GNT_INST) begin
          mst_wr       = inst_wr;
          mst_size     = inst_size;
          mst_addr     = inst_addr;
          mst_wdata    = inst_wdata;
          inst_addr_ok = mst_addr_ok;
        end else begin
          mst_wr       = data_wr;
          mst_size     = data_size;
          mst_addr     = data_addr;
          mst_wdata    = data_wdata;
          data_addr_ok = mst_addr_ok;
        end
        if (mst_addr_ok) begin
          state_nxt = S_DATA;
        end else if (!gnt_req) begin
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (grant == GNT_INST) begin
          inst_data_ok = mst_data_ok;
        end else begin
          data_data_ok = mst_data_ok;
        end
        if (mst_data_ok) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign inst_rdata = mst_rdata;
  assign data_rdata = mst_rdata;

endmodule
